// File: rtl/payload_match_collector_if.sv
// rtl/payload_match_collector_if.sv - report beat stream between the match collector and its consumer
interface payload_match_collector_if #(
  parameter int ID_W = 4
);
  logic            id_valid;
  logic            id_ready;
  logic [ID_W-1:0] id_out;
  logic            id_last;
  logic            id_none;

  modport master (
    output id_valid,
    output id_out,
    output id_last,
    output id_none,
    input  id_ready
  );

  modport slave (
    input  id_valid,
    input  id_out,
    input  id_last,
    input  id_none,
    output id_ready
  );
endinterface

// File: rtl/payload_match_collector.sv
// rtl/payload_match_collector.sv - collects sticky engine match bits per packet and reports matched engine indices
module payload_match_collector #(
  parameter int NUM_ENGINES = 16,
  parameter int ID_W        = 4   // must equal $clog2(NUM_ENGINES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sod,
  input  logic                   en,
  input  logic                   eod,
  input  logic [NUM_ENGINES-1:0] match_in,
  payload_match_collector_if.master rpt,
  output logic                   overrun,
  output logic                   busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REPORT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_ENGINES-1:0] live_q, live_d;
  logic [NUM_ENGINES-1:0] snap_q, snap_d;
  logic                   id_valid_q;
  logic [ID_W-1:0]        id_out_q;
  logic                   id_last_q;
  logic                   id_none_q;
  logic                   overrun_q;
  logic                   handshake;

  // Engine outputs are already sticky, so the enable plays no part in collection.
  logic unused_en;
  assign unused_en = en;

  // Lowest set index wins; scanning downward leaves the smallest match as the result.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_ENGINES-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  // True when at most one bit is set: clearing the lowest set bit leaves nothing.
  function automatic logic at_most_one(input logic [NUM_ENGINES-1:0] v);
    at_most_one = ((v & (v - NUM_ENGINES'(1))) == '0);
  endfunction

  assign handshake = id_valid_q & rpt.id_ready;

  // Next-state: snapshot on eod in IDLE, retire one beat per handshake in REPORT.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    case (state_q)
      S_IDLE: begin
        if (eod) begin
          snap_d  = live_q | match_in;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        if (handshake) begin
          snap_d = snap_q & (snap_q - NUM_ENGINES'(1));
          if (at_most_one(snap_q)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // eod closes the old packet before sod clears it, so either one empties the live vector.
    live_d = (sod || eod) ? '0 : (live_q | match_in);
  end

  // State and registered report outputs, computed from the next snapshot so they hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      live_q     <= '0;
      snap_q     <= '0;
      id_valid_q <= 1'b0;
      id_out_q   <= '0;
      id_last_q  <= 1'b0;
      id_none_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      snap_q     <= snap_d;
      id_valid_q <= (state_d == S_REPORT);
      id_out_q   <= (state_d == S_REPORT) ? lowest_idx(snap_d) : '0;
      id_last_q  <= (state_d == S_REPORT) && at_most_one(snap_d);
      id_none_q  <= (state_d == S_REPORT) && (snap_d == '0);
      overrun_q  <= (state_q == S_REPORT) && eod;
    end
  end

  assign rpt.id_valid = id_valid_q;
  assign rpt.id_out   = id_out_q;
  assign rpt.id_last  = id_last_q;
  assign rpt.id_none  = id_none_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q == S_REPORT);

endmodule

// File: tb/tb_payload_match_collector.sv
// tb/tb_payload_match_collector.sv - self-checking bench for payload_match_collector
module tb_payload_match_collector;
  localparam int N  = 16;
  localparam int IW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         sod;
  logic         en;
  logic         eod;
  logic [N-1:0] match_in;
  logic         overrun;
  logic         busy;

  always #5 clk = ~clk;

  payload_match_collector_if #(.ID_W(IW)) rpt_if ();

  payload_match_collector #(.NUM_ENGINES(N), .ID_W(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .sod      (sod),
    .en       (en),
    .eod      (eod),
    .match_in (match_in),
    .rpt      (rpt_if),
    .overrun  (overrun),
    .busy     (busy)
  );

  // {valid, id_out[3:0], last, none, overrun, busy}
  logic [8:0] obs;
  assign obs = {rpt_if.id_valid, rpt_if.id_out, rpt_if.id_last, rpt_if.id_none, overrun, busy};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (valid,id4,last,none,ovr,busy)", name, got, exp);
  endtask

  function automatic logic [8:0] pk(input bit v, input int id, input bit last, input bit none, input bit ov);
    logic [3:0] idb;
    idb = 4'(id);
    return {v, idb, last, none, ov, v};
  endfunction

  // Reference model: a queue of pending report beats built from the packet's match set.
  logic [N-1:0] m_live;
  int           q_id[$];
  bit           q_last[$];
  bit           q_none[$];
  bit           m_over;

  task automatic model_reset();
    m_live = '0;
    m_over = 1'b0;
    q_id.delete();
    q_last.delete();
    q_none.delete();
  endtask

  task automatic model_edge();
    bit           was_busy;
    int           cnt;
    int           n;
    logic [N-1:0] v;
    was_busy = (q_id.size() > 0);
    m_over   = was_busy && eod;
    if (was_busy && rpt_if.id_ready) begin
      void'(q_id.pop_front());
      void'(q_last.pop_front());
      void'(q_none.pop_front());
    end
    if (eod && !was_busy) begin
      v   = m_live | match_in;
      cnt = $countones(v);
      if (cnt == 0) begin
        q_id.push_back(0);
        q_last.push_back(1'b1);
        q_none.push_back(1'b1);
      end else begin
        n = 0;
        for (int k = 0; k < N; k++) begin
          if (v[k]) begin
            n++;
            q_id.push_back(k);
            q_last.push_back(n == cnt);
            q_none.push_back(1'b0);
          end
        end
      end
    end
    m_live = (sod || eod) ? '0 : (m_live | match_in);
  endtask

  function automatic logic [8:0] model_obs();
    if (q_id.size() == 0) return pk(1'b0, 0, 1'b0, 1'b0, m_over);
    return pk(1'b1, q_id[0], q_last[0], q_none[0], m_over);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic drive(input bit s, input bit e, input bit r, input logic [N-1:0] m);
    sod              = s;
    eod              = e;
    rpt_if.id_ready  = r;
    match_in         = m;
  endtask

  typedef struct {
    bit         sod;
    bit         eod;
    bit         rdy;
    logic [15:0] m;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit s, input bit e, input bit r, input logic [15:0] m, input logic [8:0] x);
    vec_t t;
    t.sod = s; t.eod = e; t.rdy = r; t.m = m; t.exp = x;
    tbl.push_back(t);
  endtask

  initial begin
    logic [8:0] idle;
    idle = pk(1'b0, 0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    en  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs, idle);
    rst = 1'b0;

    // empty packet -> single none beat
    add(1, 0, 1, 16'h0000, idle);
    add(0, 0, 1, 16'h0000, idle);
    add(0, 1, 1, 16'h0000, pk(1, 0, 1, 1, 0));
    add(0, 0, 1, 16'h0000, idle);
    // engines 3 and 9, back-to-back beats
    add(1, 0, 1, 16'h0000, idle);
    add(0, 0, 1, 16'h0008, idle);
    add(0, 0, 1, 16'h0200, idle);
    add(0, 1, 1, 16'h0000, pk(1, 3, 0, 0, 0));
    add(0, 0, 1, 16'h0000, pk(1, 9, 1, 0, 0));
    add(0, 0, 1, 16'h0000, idle);
    // sod with eod: old packet reported, new packet starts empty
    add(1, 0, 1, 16'h0000, idle);
    add(0, 0, 1, 16'h0004, idle);
    add(1, 1, 1, 16'h0000, pk(1, 2, 1, 0, 0));
    add(0, 0, 1, 16'h0000, idle);
    add(0, 1, 1, 16'h0000, pk(1, 0, 1, 1, 0));
    add(0, 0, 1, 16'h0000, idle);
    // eod during a 3-beat report: dropped, overrun pulse, beats unaltered
    add(1, 0, 1, 16'h0000, idle);
    add(0, 0, 1, 16'h0013, idle);
    add(0, 1, 1, 16'h0000, pk(1, 0, 0, 0, 0));
    add(0, 1, 1, 16'hFFFF, pk(1, 1, 0, 0, 1));
    add(0, 0, 1, 16'h0000, pk(1, 4, 1, 0, 0));
    add(0, 0, 1, 16'h0000, idle);
    add(0, 1, 1, 16'h0000, pk(1, 0, 1, 1, 0));
    add(0, 0, 1, 16'h0000, idle);

    foreach (tbl[i]) begin
      drive(tbl[i].sod, tbl[i].eod, tbl[i].rdy, tbl[i].m);
      tick();
      check($sformatf("vec%0d", i), obs, tbl[i].exp);
    end

    // backpressure: first beat held stable for 5 stalled cycles
    drive(1, 0, 0, 16'h0000); tick(); check("bp_sod", obs, idle);
    drive(0, 0, 0, 16'h8001); tick(); check("bp_live", obs, idle);
    drive(0, 1, 0, 16'h0000); tick(); check("bp_stall0", obs, pk(1, 0, 0, 0, 0));
    drive(0, 0, 0, 16'h0000);
    for (int s = 1; s < 5; s++) begin
      tick();
      check($sformatf("bp_stall%0d", s), obs, pk(1, 0, 0, 0, 0));
    end
    drive(0, 0, 1, 16'h0000); tick(); check("bp_beat15", obs, pk(1, 15, 1, 0, 0));
    tick(); check("bp_done", obs, idle);

    // reset mid-report discards pending beats
    drive(1, 0, 1, 16'h0000); tick(); check("rr_sod", obs, idle);
    drive(0, 0, 1, 16'h00A6); tick(); check("rr_live", obs, idle);
    drive(0, 1, 1, 16'h0000); tick(); check("rr_beat1", obs, pk(1, 1, 0, 0, 0));
    drive(0, 0, 1, 16'h0000); tick(); check("rr_beat2", obs, pk(1, 2, 0, 0, 0));
    rst = 1'b1;
    #1;
    check("rr_async", obs, idle);
    tick(); check("rr_held", obs, idle);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      check($sformatf("rr_quiet%0d", s), obs, idle);
    end
    drive(0, 1, 1, 16'h0040); tick(); check("rr_first_eod", obs, pk(1, 6, 1, 0, 0));
    drive(0, 0, 1, 16'h0000); tick(); check("rr_after", obs, idle);

    // randomized traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] m;
      m = N'($urandom) & N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) m = '0;
      en = 1'($urandom);
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), m);
      tick();
      check($sformatf("rand%0d", c), obs, model_obs());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
